rv_encoder: RTL and testbench

- Streaming RV64IM instruction encoder: the inverse of the instruction decoder.
- Accepts decoded fields (format, major opcode, funct3, funct7, rs1, rs2, rd, signed immediate) over a valid/ready handshake.
- Packs the fields into a 32-bit instruction word, checks that the fields are legal, and buffers results in a 2-entry output FIFO.
- Used by the self-check bench and the program loader to produce instruction streams for fetch/decode.

---
 rtl/rv_enc_pkg.sv | 33 +++
 rtl/rv_encoder_if.sv | 29 ++
 rtl/rv_enc_fifo2.sv | 39 +++
 rtl/rv_encoder.sv | 112 +++++++++++
 tb/tb_rv_encoder.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_enc_pkg.sv
// rv_enc_pkg: shared widths, format enum, opcode map and FIFO entry type for rv_encoder.
package rv_enc_pkg;
    localparam int INSTRSZ = 32;
    localparam int REGBITS = 5;
    localparam int IMMW    = 32;
    localparam int CNTW    = 32;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } enc_fmt_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_RW     = 7'b0111011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMMW   = 7'b0011011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [INSTRSZ-1:0] instr;
        logic               illegal;
    } enc_entry_t;
endpackage

// File: rtl/rv_encoder_if.sv
// rv_encoder_if: field-set input stream, encoded-word output stream and statistics counters.
interface rv_encoder_if;
    import rv_enc_pkg::*;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_fmt;
    logic [6:0]         in_opcode;
    logic [2:0]         in_funct3;
    logic [6:0]         in_funct7;
    logic [REGBITS-1:0] in_rs1;
    logic [REGBITS-1:0] in_rs2;
    logic [REGBITS-1:0] in_rd;
    logic [IMMW-1:0]    in_imm;
    logic               out_valid;
    logic               out_ready;
    logic [INSTRSZ-1:0] out_instr;
    logic               out_illegal;
    logic [CNTW-1:0]    enc_count;
    logic [CNTW-1:0]    err_count;

    modport master (
        output in_valid, in_fmt, in_opcode, in_funct3, in_funct7, in_rs1, in_rs2, in_rd, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_illegal, enc_count, err_count
    );
    modport slave (
        input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7, in_rs1, in_rs2, in_rd, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_illegal, enc_count, err_count
    );
endinterface

// File: rtl/rv_enc_fifo2.sv
// rv_enc_fifo2: 2-entry valid/ready FIFO; the head register keeps its last value when the FIFO drains.
module rv_enc_fifo2 import rv_enc_pkg::*; (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_push_valid,
    output logic       o_push_ready,
    input  enc_entry_t i_data,
    output logic       o_pop_valid,
    input  logic       i_pop_ready,
    output enc_entry_t o_data
);
    logic [1:0] r_cnt;
    enc_entry_t r_head;
    enc_entry_t r_tail;
    logic       w_push;
    logic       w_pop;

    assign o_push_ready = (r_cnt != 2'd2);
    assign o_pop_valid  = (r_cnt != 2'd0);
    assign o_data       = r_head;
    assign w_push       = i_push_valid && o_push_ready;
    assign w_pop        = o_pop_valid && i_pop_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
            if (w_push && (r_cnt == 2'd0 || (r_cnt == 2'd1 && w_pop)))
                r_head <= i_data;
            else if (w_pop && r_cnt == 2'd2)
                r_head <= r_tail;
            if (w_push && r_cnt == 2'd1 && !w_pop)
                r_tail <= i_data;
        end
    end
endmodule

// File: rtl/rv_encoder.sv
// rv_encoder: packs decoded RV64IM fields into 32-bit words with legality checking.
// Define RV_ENC_MEXT_EN to accept funct7=0000001 (MUL/DIV/REM) on OP/OP-32.
module rv_encoder import rv_enc_pkg::*; (
    input logic         clk,
    input logic         reset_n,
    rv_encoder_if.slave bus
);
`ifdef RV_ENC_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    enc_fmt_t                  w_fmt;
    logic [6:0]                w_op;
    logic [2:0]                w_f3;
    logic [6:0]                w_f7;
    logic [REGBITS-1:0]        w_rs1;
    logic [REGBITS-1:0]        w_rs2;
    logic [REGBITS-1:0]        w_rd;
    logic signed [IMMW-1:0]    w_imm;
    logic                      w_shift;
    logic                      w_ok;
    logic [INSTRSZ-1:0]        w_raw;
    logic                      w_accept;
    enc_entry_t                w_entry;
    enc_entry_t                w_head;
    logic [CNTW-1:0]           r_enc_count;
    logic [CNTW-1:0]           r_err_count;

    assign w_fmt = enc_fmt_t'(bus.in_fmt);
    assign w_op  = bus.in_opcode;
    assign w_f3  = bus.in_funct3;
    assign w_f7  = bus.in_funct7;
    assign w_rs1 = bus.in_rs1;
    assign w_rs2 = bus.in_rs2;
    assign w_rd  = bus.in_rd;
    assign w_imm = $signed(bus.in_imm);
    assign w_shift = (w_op == OP_IMM || w_op == OP_IMMW) && (w_f3 == 3'b001 || w_f3 == 3'b101);

    always_comb begin
        w_raw = '0;
        w_ok  = 1'b0;
        case (w_fmt)
            FMT_R: begin
                w_raw = {w_f7, w_rs2, w_rs1, w_f3, w_rd, w_op};
                w_ok  = (w_op == OP_R || w_op == OP_RW) &&
                        (w_f7 == 7'b0000000 || w_f7 == 7'b0100000 || (w_f7 == 7'b0000001 && MEXT));
            end
            FMT_I: begin
                // Shift-immediates carry funct7[6:1] above a 6-bit shamt instead of a 12-bit immediate.
                w_raw = w_shift ? {w_f7[6:1], w_imm[5:0], w_rs1, w_f3, w_rd, w_op}
                                : {w_imm[11:0], w_rs1, w_f3, w_rd, w_op};
                w_ok  = (w_op == OP_IMM || w_op == OP_IMMW || w_op == OP_LOAD || w_op == OP_JALR) &&
                        (w_shift ? (w_imm >= 32'sd0 && w_imm <= (w_op == OP_IMM ? 32'sd63 : 32'sd31) &&
                                    (w_f7[6:1] == 6'b000000 || w_f7[6:1] == 6'b010000))
                                 : (w_imm >= -32'sd2048 && w_imm <= 32'sd2047));
            end
            FMT_S: begin
                w_raw = {w_imm[11:5], w_rs2, w_rs1, w_f3, w_imm[4:0], w_op};
                w_ok  = w_op == OP_STORE && w_imm >= -32'sd2048 && w_imm <= 32'sd2047;
            end
            FMT_B: begin
                w_raw = {w_imm[12], w_imm[10:5], w_rs2, w_rs1, w_f3, w_imm[4:1], w_imm[11], w_op};
                w_ok  = w_op == OP_BRANCH && w_imm >= -32'sd4096 && w_imm <= 32'sd4094 && !w_imm[0];
            end
            FMT_U: begin
                w_raw = {w_imm[31:12], w_rd, w_op};
                w_ok  = (w_op == OP_LUI || w_op == OP_AUIPC) && w_imm[11:0] == 12'd0;
            end
            FMT_J: begin
                w_raw = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], w_rd, w_op};
                w_ok  = w_op == OP_JAL && w_imm >= -32'sd1048576 && w_imm <= 32'sd1048574 && !w_imm[0];
            end
            default: begin
                w_raw = '0;
                w_ok  = 1'b0;
            end
        endcase
    end

    assign w_entry  = '{instr: (w_ok ? w_raw : '0), illegal: !w_ok};
    assign w_accept = bus.in_valid && bus.in_ready;

    rv_enc_fifo2 u_fifo (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_push_valid (bus.in_valid),
        .o_push_ready (bus.in_ready),
        .i_data       (w_entry),
        .o_pop_valid  (bus.out_valid),
        .i_pop_ready  (bus.out_ready),
        .o_data       (w_head)
    );

    assign bus.out_instr   = w_head.instr;
    assign bus.out_illegal = w_head.illegal;
    assign bus.enc_count   = r_enc_count;
    assign bus.err_count   = r_err_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_enc_count <= '0;
            r_err_count <= '0;
        end else if (w_accept) begin
            if (w_ok)
                r_enc_count <= r_enc_count + CNTW'(1);
            else
                r_err_count <= r_err_count + CNTW'(1);
        end
    end
endmodule

// File: tb/tb_rv_encoder.sv
// tb_rv_encoder: randomized and directed self-checking bench for rv_encoder against a field-rule model.
module tb_rv_encoder;
    import rv_enc_pkg::*;
`ifdef RV_ENC_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    logic [CNTW-1:0] exp_enc = '0;
    logic [CNTW-1:0] exp_err = '0;
    logic [6:0] ops [11] = '{OP_R, OP_RW, OP_IMM, OP_IMMW, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL};
    int bnd [18] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4097,
                     1048574, 1048576, -1048576, -1048578, 63, 64, 31, 32, 0};

    always #5 clk = ~clk;

    rv_encoder_if bus ();
    rv_encoder dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: returns {illegal, instr}, built field by field from the ISA encoding rules.
    function automatic logic [32:0] model(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [4:0] rd, input logic [31:0] imm);
        longint v;
        bit ok;
        bit sh;
        logic [31:0] w;
        v = $signed(imm);
        w = 32'd0;
        ok = 0;
        w[6:0] = op;
        sh = (op == OP_IMM || op == OP_IMMW) && (f3 == 3'b001 || f3 == 3'b101);
        case (fmt)
            3'd0: begin
                w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1; w[24:20] = rs2; w[31:25] = f7;
                ok = (op == OP_R || op == OP_RW) && (f7 == 7'h00 || f7 == 7'h20 || (f7 == 7'h01 && MEXT));
            end
            3'd1: begin
                w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1;
                if (sh) begin
                    w[25:20] = imm[5:0]; w[31:26] = f7[6:1];
                    ok = v >= 0 && v <= ((op == OP_IMM) ? 63 : 31) && (f7[6:1] == 6'd0 || f7[6:1] == 6'd16);
                end else begin
                    w[31:20] = imm[11:0];
                    ok = v >= -2048 && v <= 2047;
                end
                ok = ok && (op == OP_IMM || op == OP_IMMW || op == OP_LOAD || op == OP_JALR);
            end
            3'd2: begin
                w[11:7] = imm[4:0]; w[14:12] = f3; w[19:15] = rs1; w[24:20] = rs2; w[31:25] = imm[11:5];
                ok = op == OP_STORE && v >= -2048 && v <= 2047;
            end
            3'd3: begin
                w[7] = imm[11]; w[11:8] = imm[4:1]; w[14:12] = f3; w[19:15] = rs1; w[24:20] = rs2;
                w[30:25] = imm[10:5]; w[31] = imm[12];
                ok = op == OP_BRANCH && v >= -4096 && v <= 4094 && (v % 2 == 0);
            end
            3'd4: begin
                w[11:7] = rd; w[31:12] = imm[31:12];
                ok = (op == OP_LUI || op == OP_AUIPC) && (v % 4096 == 0);
            end
            3'd5: begin
                w[11:7] = rd; w[19:12] = imm[19:12]; w[20] = imm[11]; w[30:21] = imm[10:1]; w[31] = imm[20];
                ok = op == OP_JAL && v >= -1048576 && v <= 1048574 && (v % 2 == 0);
            end
            default: ok = 0;
        endcase
        return ok ? {1'b0, w} : {1'b1, 32'd0};
    endfunction

    function automatic logic [2:0] fmt_of(input logic [6:0] op);
        if (op == OP_R || op == OP_RW) return 3'd0;
        if (op == OP_STORE) return 3'd2;
        if (op == OP_BRANCH) return 3'd3;
        if (op == OP_LUI || op == OP_AUIPC) return 3'd4;
        if (op == OP_JAL) return 3'd5;
        return 3'd1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm);
        bus.in_fmt = fmt; bus.in_opcode = op; bus.in_funct3 = f3; bus.in_funct7 = f7;
        bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd; bus.in_imm = imm;
    endtask

    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm);
        logic [32:0] m;
        int w;
        drive(fmt, op, f3, f7, rs1, rs2, rd, imm);
        bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            step();
            w++;
        end
        if (!bus.in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: in_ready=%0b required 1", bus.in_ready);
        end else begin
            m = model(fmt, op, f3, f7, rs1, rs2, rd, imm);
            if (m[32]) exp_err++; else exp_enc++;
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        drive(3'd0, OP_R, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        step(); step();
        reset_n = 1'b1;
        exp_enc = '0; exp_err = '0;
        n_checks += 6;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b required 0", bus.out_valid); end
        if (bus.out_instr !== 32'd0) begin n_fail++; $display("FAIL reset_out_instr: got %h required 0", bus.out_instr); end
        if (bus.out_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_out_illegal: got %0b required 0", bus.out_illegal); end
        if (bus.enc_count !== '0) begin n_fail++; $display("FAIL reset_enc_count: got %0d required 0", bus.enc_count); end
        if (bus.err_count !== '0) begin n_fail++; $display("FAIL reset_err_count: got %0d required 0", bus.err_count); end
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b required 1", bus.in_ready); end
    endtask

    task automatic test_directed();
        logic [2:0] fm [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
        logic [6:0] op [4] = '{OP_R, OP_IMM, OP_STORE, OP_LUI};
        logic [2:0] f3 [4] = '{3'd0, 3'd0, 3'd3, 3'd0};
        logic [4:0] r1 [4] = '{5'd1, 5'd0, 5'd2, 5'd0};
        logic [4:0] r2 [4] = '{5'd2, 5'd0, 5'd5, 5'd0};
        logic [4:0] rd [4] = '{5'd3, 5'd1, 5'd0, 5'd5};
        logic [31:0] im [4] = '{32'd0, 32'hFFFFFFFF, 32'd8, 32'h12345000};
        logic [31:0] ex [4] = '{32'h002081B3, 32'hFFF00093, 32'h00513423, 32'h123452B7};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(fm[i], op[i], f3[i], 7'd0, r1[i], r2[i], rd[i], im[i]);
            n_checks += 3;
            if (bus.out_valid !== 1'b1 || bus.out_instr !== ex[i])
                begin n_fail++; $display("FAIL directed_%0d_instr: got v=%0b %h required v=1 %h", i, bus.out_valid, bus.out_instr, ex[i]); end
            if (bus.out_illegal !== 1'b0) begin n_fail++; $display("FAIL directed_%0d_illegal: got %0b required 0", i, bus.out_illegal); end
            if (bus.enc_count !== CNTW'(i + 1)) begin n_fail++; $display("FAIL directed_%0d_enc_count: got %0d required %0d", i, bus.enc_count, i + 1); end
            step();
        end
    endtask

    task automatic test_illegal();
        logic [2:0] fm [7] = '{3'd5, 3'd4, 3'd6, 3'd1, 3'd1, 3'd3, 3'd2};
        logic [6:0] op [7] = '{OP_JAL, OP_LUI, OP_R, OP_IMMW, OP_IMM, OP_BRANCH, OP_BRANCH};
        logic [2:0] f3 [7] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd5, 3'd1, 3'd0};
        logic [6:0] f7 [7] = '{7'd0, 7'd0, 7'd0, 7'd0, 7'h20, 7'd0, 7'd0};
        logic [31:0] im [7] = '{32'd1048574, 32'h00001001, 32'd0, 32'd32, 32'd63, 32'hFFFFF000, 32'd4};
        logic [32:0] m;
        bus.out_ready = 1'b1;
        send(3'd3, OP_BRANCH, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd3);
        n_checks += 3;
        if (bus.out_illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_b_odd: got %0b required 1", bus.out_illegal); end
        if (bus.out_instr !== 32'd0) begin n_fail++; $display("FAIL illegal_b_instr: got %h required 0", bus.out_instr); end
        if (bus.err_count !== CNTW'(1)) begin n_fail++; $display("FAIL illegal_err_count: got %0d required 1", bus.err_count); end
        step();
        send(3'd1, OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd2, 32'd2048);
        n_checks++;
        if (bus.out_illegal !== 1'b1 || bus.out_instr !== 32'd0)
            begin n_fail++; $display("FAIL illegal_i_2048: got ill=%0b %h required ill=1 0", bus.out_illegal, bus.out_instr); end
        step();
        for (int i = 0; i < 7; i++) begin
            m = model(fm[i], op[i], f3[i], f7[i], 5'd4, 5'd6, 5'd9, im[i]);
            send(fm[i], op[i], f3[i], f7[i], 5'd4, 5'd6, 5'd9, im[i]);
            n_checks++;
            if ({bus.out_illegal, bus.out_instr} !== m)
                begin n_fail++; $display("FAIL boundary_%0d: got ill=%0b %h required ill=%0b %h", i, bus.out_illegal, bus.out_instr, m[32], m[31:0]); end
            step();
        end
        n_checks += 2;
        if (bus.enc_count !== exp_enc) begin n_fail++; $display("FAIL illegal_enc_total: got %0d required %0d", bus.enc_count, exp_enc); end
        if (bus.err_count !== exp_err) begin n_fail++; $display("FAIL illegal_err_total: got %0d required %0d", bus.err_count, exp_err); end
    endtask

    task automatic test_backpressure();
        logic [32:0] ma, mb, mc;
        ma = model(3'd0, OP_R, 3'd0, 7'h20, 5'd1, 5'd2, 5'd4, 32'd0);
        mb = model(3'd1, OP_IMM, 3'd0, 7'd0, 5'd7, 5'd0, 5'd6, 32'd100);
        mc = model(3'd2, OP_STORE, 3'd3, 7'd0, 5'd2, 5'd5, 5'd0, 32'hFFFFFFF8);
        bus.out_ready = 1'b0;
        drive(3'd0, OP_R, 3'd0, 7'h20, 5'd1, 5'd2, 5'd4, 32'd0);
        bus.in_valid = 1'b1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_a: got %0b required 1", bus.in_ready); end
        step();
        drive(3'd1, OP_IMM, 3'd0, 7'd0, 5'd7, 5'd0, 5'd6, 32'd100);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_b: got %0b required 1", bus.in_ready); end
        step();
        exp_enc += 2;
        drive(3'd2, OP_STORE, 3'd3, 7'd0, 5'd2, 5'd5, 5'd0, 32'hFFFFFFF8);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: got in_ready=%0b required 0", bus.in_ready); end
        step(); step();
        n_checks += 3;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_held: got in_ready=%0b required 0", bus.in_ready); end
        if ({bus.out_illegal, bus.out_instr} !== ma) begin n_fail++; $display("FAIL bp_head_a: got %h required %h", bus.out_instr, ma[31:0]); end
        if (bus.enc_count !== exp_enc) begin n_fail++; $display("FAIL bp_enc_held: got %0d required %0d", bus.enc_count, exp_enc); end
        bus.out_ready = 1'b1;
        step();
        n_checks += 2;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop: got %0b required 1", bus.in_ready); end
        if ({bus.out_illegal, bus.out_instr} !== mb) begin n_fail++; $display("FAIL bp_head_b: got %h required %h", bus.out_instr, mb[31:0]); end
        step();
        exp_enc++;
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || {bus.out_illegal, bus.out_instr} !== mc)
            begin n_fail++; $display("FAIL bp_head_c: got v=%0b %h required v=1 %h", bus.out_valid, bus.out_instr, mc[31:0]); end
        step();
        n_checks += 3;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got out_valid=%0b required 0", bus.out_valid); end
        if (bus.out_instr !== mc[31:0]) begin n_fail++; $display("FAIL bp_hold_last: got %h required %h", bus.out_instr, mc[31:0]); end
        if (bus.enc_count !== exp_enc) begin n_fail++; $display("FAIL bp_enc: got %0d required %0d", bus.enc_count, exp_enc); end
    endtask

    task automatic test_mext();
        logic [32:0] req;
        req = MEXT ? {1'b0, 32'h022081B3} : {1'b1, 32'd0};
        bus.out_ready = 1'b1;
        send(3'd0, OP_R, 3'd0, 7'h01, 5'd1, 5'd2, 5'd3, 32'd0);
        n_checks++;
        if ({bus.out_illegal, bus.out_instr} !== req)
            begin n_fail++; $display("FAIL mul: got ill=%0b %h required ill=%0b %h", bus.out_illegal, bus.out_instr, req[32], req[31:0]); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [32:0] m;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(3'd1, OP_IMM, 3'd0, 7'd0, 5'(i + 1), 5'd0, 5'(i + 10), 32'(i * 3 - 5));
            m = model(3'd1, OP_IMM, 3'd0, 7'd0, 5'(i + 1), 5'd0, 5'(i + 10), 32'(i * 3 - 5));
            bus.in_valid = 1'b1;
            n_checks++;
            if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d: got %0b required 1", i, bus.in_ready); end
            step();
            exp_enc++;
            n_checks++;
            if (bus.out_valid !== 1'b1 || {bus.out_illegal, bus.out_instr} !== m)
                begin n_fail++; $display("FAIL b2b_head_%0d: got v=%0b %h required v=1 %h", i, bus.out_valid, bus.out_instr, m[31:0]); end
        end
        bus.in_valid = 1'b0;
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got out_valid=%0b required 0", bus.out_valid); end
    endtask

    task automatic test_random();
        logic [32:0] q [$];
        logic [32:0] e;
        logic [2:0] fm, f3;
        logic [6:0] op, f7;
        logic [4:0] r1, r2, rd;
        logic [31:0] im;
        bit acc, pop;
        int k;
        for (int c = 0; c < 600; c++) begin
            op = ops[$urandom_range(0, 10)];
            fm = ($urandom_range(0, 4) != 0) ? fmt_of(op) : 3'($urandom_range(0, 7));
            f3 = 3'($urandom_range(0, 7));
            k = $urandom_range(0, 4);
            f7 = (k == 1) ? 7'h20 : (k == 2) ? 7'h01 : (k == 3) ? 7'($urandom) : 7'h00;
            r1 = 5'($urandom); r2 = 5'($urandom); rd = 5'($urandom);
            k = $urandom_range(0, 3);
            if (k == 0) im = $urandom;
            else if (k == 1) im = 32'(int'($urandom_range(0, 8192)) - 4096);
            else if (k == 2) im = 32'(bnd[$urandom_range(0, 17)]);
            else begin im = $urandom; im = im & 32'hFFFFF000; end
            drive(fm, op, f3, f7, r1, r2, rd, im);
            bus.in_valid = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            acc = bus.in_valid && q.size() < 2;
            pop = bus.out_ready && q.size() != 0;
            n_checks += 2;
            if (bus.in_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd_in_ready_%0d: got %0b required %0b", c, bus.in_ready, q.size() < 2); end
            if (bus.out_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_out_valid_%0d: got %0b required %0b", c, bus.out_valid, q.size() != 0); end
            if (pop) begin
                e = q.pop_front();
                n_checks++;
                if ({bus.out_illegal, bus.out_instr} !== e)
                    begin n_fail++; $display("FAIL rnd_entry_%0d: got ill=%0b %h required ill=%0b %h", c, bus.out_illegal, bus.out_instr, e[32], e[31:0]); end
            end
            if (acc) begin
                e = model(fm, op, f3, f7, r1, r2, rd, im);
                q.push_back(e);
                if (e[32]) exp_err++; else exp_enc++;
            end
            step();
        end
        bus.in_valid = 1'b0;
        n_checks += 2;
        if (bus.enc_count !== exp_enc) begin n_fail++; $display("FAIL rnd_enc_count: got %0d required %0d", bus.enc_count, exp_enc); end
        if (bus.err_count !== exp_err) begin n_fail++; $display("FAIL rnd_err_count: got %0d required %0d", bus.err_count, exp_err); end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() != 0; c++) begin
            e = q.pop_front();
            n_checks++;
            if (bus.out_valid !== 1'b1 || {bus.out_illegal, bus.out_instr} !== e)
                begin n_fail++; $display("FAIL rnd_drain: got v=%0b %h required v=1 %h", bus.out_valid, bus.out_instr, e[31:0]); end
            step();
        end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_empty: got out_valid=%0b required 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        drive(3'd0, OP_R, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        bus.in_valid = 1'b1;
        step(); step();
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_full: got in_ready=%0b required 0", bus.in_ready); end
        bus.out_ready = 1'b1;
        reset_n = 1'b0;
        step();
        n_checks += 5;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %0b required 0", bus.out_valid); end
        if (bus.out_instr !== 32'd0) begin n_fail++; $display("FAIL rmid_out_instr: got %h required 0", bus.out_instr); end
        if (bus.enc_count !== '0) begin n_fail++; $display("FAIL rmid_enc_count: got %0d required 0", bus.enc_count); end
        if (bus.err_count !== '0) begin n_fail++; $display("FAIL rmid_err_count: got %0d required 0", bus.err_count); end
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %0b required 1", bus.in_ready); end
        reset_n = 1'b1;
        bus.in_valid = 1'b0;
        step();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_illegal();
        test_backpressure();
        test_mext();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
